// File: rtl/sd_spi_pkg.sv
// sd_spi_pkg
//   Shared definitions for the SD-card SPI datapath: the MISO receiver, the MOSI byte
//   shifter and the SD command FSM all import this package.
//   Contents: transaction mode encodings, reply token constants, receiver FSM states,
//   CRC16-CCITT polynomial and a small error-token classifier.
package sd_spi_pkg;

    // Transaction modes selected by the command FSM when it raises en.
    typedef enum logic [1:0] {
        MODE_RAW   = 2'd0,
        MODE_R1    = 2'd1,
        MODE_BLOCK = 2'd2
    } sd_mode_e;

    localparam logic [7:0]  TOKEN_START    = 8'hFE;
    localparam logic [7:0]  IDLE_BYTE      = 8'hFF;
    localparam logic [2:0]  ERR_TOKEN_MASK = 3'b000;
    localparam logic [15:0] CRC16_POLY     = 16'h1021;

    // Receiver framing states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RAW,
        ST_HUNT,
        ST_DATA,
        ST_CRC,
        ST_DONE
    } rx_state_e;

    // A data error token is any byte whose top three bits are zero.
    function automatic logic is_error_token(input logic [7:0] b);
        return (b[7:5] == ERR_TOKEN_MASK);
    endfunction

endpackage

// File: rtl/sd_spi_rx_if.sv
// sd_spi_rx_if
//   Bundle between the SD command FSM (master) and the MISO receiver (slave).
//   master drives: sclk_rise, en, mode, miso
//   slave drives : rx_data, rx_valid, busy, done, timeout, token_err, crc_ok
interface sd_spi_rx_if;
    import sd_spi_pkg::*;

    logic       sclk_rise;
    logic       en;
    sd_mode_e   mode;
    logic       miso;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       done;
    logic       timeout;
    logic       token_err;
    logic       crc_ok;

    modport master (
        output sclk_rise, en, mode, miso,
        input  rx_data, rx_valid, busy, done, timeout, token_err, crc_ok
    );

    modport slave (
        input  sclk_rise, en, mode, miso,
        output rx_data, rx_valid, busy, done, timeout, token_err, crc_ok
    );

endinterface

// File: rtl/sd_crc16.sv
// sd_crc16
//   Bit-serial CRC16-CCITT (poly 0x1021, init 0), MSB-first data.
//   Ports: clk, rst (sync, active-high), clr (sync clear to 0, wins over bit_en),
//          bit_en (advance by one bit), bit_in (data bit), crc[15:0] (running remainder).
module sd_crc16
    import sd_spi_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        bit_en,
    input  logic        bit_in,
    output logic [15:0] crc
);

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            crc <= '0;
        end else if (bit_en) begin
            crc <= crc_step(crc, bit_in);
        end
    end

endmodule

// File: rtl/sd_spi_rx.sv
// sd_spi_rx
//   SPI MISO receiver for the SD-card interface. Samples miso on SCLK rising-edge
//   strobes, assembles MSB-first bytes and frames replies as raw bytes, an R1
//   response hunt, or a data block (start token, BLOCK_LEN payload bytes, CRC16).
//   Ports:
//     clk, rst   system clock, synchronous active-high reset
//     bus        sd_spi_rx_if.slave: sclk_rise/en/mode/miso in;
//                rx_data/rx_valid/busy/done/timeout/token_err/crc_ok out
//   Build option: define SD_RX_CRC16_EN to check the block CRC16 against the
//   payload; otherwise CRC bytes are discarded and a completed block reports crc_ok=1.
module sd_spi_rx
    import sd_spi_pkg::*;
#(
    parameter int RESP_TIMEOUT  = 8,
    parameter int TOKEN_TIMEOUT = 2048,
    parameter int BLOCK_LEN     = 512
) (
    input  logic         clk,
    input  logic         rst,
    sd_spi_rx_if.slave   bus
);

    localparam int CNT_MAX = (TOKEN_TIMEOUT > BLOCK_LEN)
                             ? ((TOKEN_TIMEOUT > RESP_TIMEOUT) ? TOKEN_TIMEOUT : RESP_TIMEOUT)
                             : ((BLOCK_LEN > RESP_TIMEOUT) ? BLOCK_LEN : RESP_TIMEOUT);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    rx_state_e        state, state_n;
    logic [1:0]       mode_r, mode_n;
    logic             en_prev;
    logic [6:0]       shift, shift_n;
    logic [2:0]       bit_cnt, bit_cnt_n;
    logic [CNT_W-1:0] byte_cnt, byte_cnt_n;
    logic [CNT_W-1:0] skip_cnt;
    logic [CNT_W-1:0] hunt_limit;
    logic [7:0]       byte_val;
    logic [7:0]       rx_data_r, rx_data_n;
    logic             rx_valid_r, rx_valid_n;
    logic             timeout_r, timeout_n;
    logic             token_err_r, token_err_n;
    logic             crc_ok_r, crc_ok_n;

`ifdef SD_RX_CRC16_EN
    logic             crc_clr;
    logic             crc_bit_en;
    logic [15:0]      crc_calc;
    logic [7:0]       crc_hi, crc_hi_n;

    sd_crc16 u_crc (
        .clk    (clk),
        .rst    (rst),
        .clr    (crc_clr),
        .bit_en (crc_bit_en),
        .bit_in (bus.miso),
        .crc    (crc_calc)
    );
`endif

    // The completed byte is the seven bits already shifted plus the bit on this strobe.
    assign byte_val   = {shift, bus.miso};
    assign skip_cnt   = byte_cnt + CNT_W'(1);
    assign hunt_limit = (mode_r == MODE_R1) ? CNT_W'(RESP_TIMEOUT) : CNT_W'(TOKEN_TIMEOUT);

    always_comb begin
        state_n     = state;
        mode_n      = mode_r;
        shift_n     = shift;
        bit_cnt_n   = bit_cnt;
        byte_cnt_n  = byte_cnt;
        rx_data_n   = rx_data_r;
        rx_valid_n  = 1'b0;
        timeout_n   = timeout_r;
        token_err_n = token_err_r;
        crc_ok_n    = crc_ok_r;
`ifdef SD_RX_CRC16_EN
        crc_clr     = 1'b0;
        crc_bit_en  = 1'b0;
        crc_hi_n    = crc_hi;
`endif

        if (!bus.en) begin
            // Dropping en wins over any strobe this cycle: the partial byte is lost.
            state_n     = ST_IDLE;
            bit_cnt_n   = 3'd7;
            byte_cnt_n  = '0;
            timeout_n   = 1'b0;
            token_err_n = 1'b0;
            crc_ok_n    = 1'b0;
`ifdef SD_RX_CRC16_EN
            crc_clr     = 1'b1;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!en_prev) begin
                        mode_n     = bus.mode;
                        bit_cnt_n  = 3'd7;
                        byte_cnt_n = '0;
                        state_n    = ((bus.mode == MODE_R1) || (bus.mode == MODE_BLOCK))
                                     ? ST_HUNT : ST_RAW;
                    end
                end

                ST_DONE: begin
                    // Hold flags, ignore strobes until en falls.
                end

                default: begin
                    if (bus.sclk_rise) begin
                        shift_n   = byte_val[6:0];
                        bit_cnt_n = bit_cnt - 3'd1;
`ifdef SD_RX_CRC16_EN
                        crc_bit_en = (state == ST_DATA);
`endif
                        if (bit_cnt == 3'd0) begin
                            bit_cnt_n = 3'd7;
                            case (state)
                                ST_RAW: begin
                                    rx_valid_n = 1'b1;
                                    rx_data_n  = byte_val;
                                end

                                ST_HUNT: begin
                                    if ((mode_r == MODE_R1) && !byte_val[7]) begin
                                        rx_valid_n = 1'b1;
                                        rx_data_n  = byte_val;
                                        state_n    = ST_DONE;
                                    end else if ((mode_r != MODE_R1) && (byte_val == TOKEN_START)) begin
                                        byte_cnt_n = '0;
                                        state_n    = ST_DATA;
`ifdef SD_RX_CRC16_EN
                                        crc_clr    = 1'b1;
`endif
                                    end else if ((mode_r != MODE_R1) && is_error_token(byte_val)) begin
                                        rx_valid_n  = 1'b1;
                                        rx_data_n   = byte_val;
                                        token_err_n = 1'b1;
                                        state_n     = ST_DONE;
                                    end else begin
                                        // IDLE_BYTE and any other non-reply byte consume budget.
                                        byte_cnt_n = skip_cnt;
                                        if (skip_cnt == hunt_limit) begin
                                            timeout_n = 1'b1;
                                            state_n   = ST_DONE;
                                        end
                                    end
                                end

                                ST_DATA: begin
                                    rx_valid_n = 1'b1;
                                    rx_data_n  = byte_val;
                                    if (byte_cnt == CNT_W'(BLOCK_LEN - 1)) begin
                                        byte_cnt_n = '0;
                                        state_n    = ST_CRC;
                                    end else begin
                                        byte_cnt_n = byte_cnt + CNT_W'(1);
                                    end
                                end

                                ST_CRC: begin
                                    if (byte_cnt == '0) begin
                                        byte_cnt_n = CNT_W'(1);
`ifdef SD_RX_CRC16_EN
                                        crc_hi_n   = byte_val;
`endif
                                    end else begin
                                        state_n  = ST_DONE;
`ifdef SD_RX_CRC16_EN
                                        crc_ok_n = (crc_calc == {crc_hi, byte_val});
`else
                                        crc_ok_n = 1'b1;
`endif
                                    end
                                end

                                default: begin
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            mode_r      <= MODE_RAW;
            en_prev     <= 1'b0;
            bit_cnt     <= 3'd7;
            byte_cnt    <= '0;
            rx_data_r   <= '0;
            rx_valid_r  <= 1'b0;
            timeout_r   <= 1'b0;
            token_err_r <= 1'b0;
            crc_ok_r    <= 1'b0;
        end else begin
            state       <= state_n;
            mode_r      <= mode_n;
            en_prev     <= bus.en;
            bit_cnt     <= bit_cnt_n;
            byte_cnt    <= byte_cnt_n;
            rx_data_r   <= rx_data_n;
            rx_valid_r  <= rx_valid_n;
            timeout_r   <= timeout_n;
            token_err_r <= token_err_n;
            crc_ok_r    <= crc_ok_n;
        end
    end

    // Shift register is pure data; the bit counter alone decides when it is meaningful.
    always_ff @(posedge clk) begin
        shift <= shift_n;
`ifdef SD_RX_CRC16_EN
        crc_hi <= crc_hi_n;
`endif
    end

    assign bus.rx_data   = rx_data_r;
    assign bus.rx_valid  = rx_valid_r;
    assign bus.busy      = (state == ST_HUNT) || (state == ST_DATA) || (state == ST_CRC);
    assign bus.done      = (state == ST_DONE);
    assign bus.timeout   = timeout_r;
    assign bus.token_err = token_err_r;
    assign bus.crc_ok    = crc_ok_r;

endmodule

// File: tb/tb_sd_spi_rx.sv
// tb_sd_spi_rx
//   Directed bench for sd_spi_rx: raw bytes, R1 hunt, hunt timeouts, a full data
//   block with CRC, an error token, and an aborted transaction.
module tb_sd_spi_rx;
    import sd_spi_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sd_spi_rx_if bus();

    sd_spi_rx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] rxq[$];

    // Collect every delivered byte just after the edge that produced it.
    always @(posedge clk) begin
        #1;
        if (bus.rx_valid === 1'b1) rxq.push_back(bus.rx_data);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic strobe_bit(input logic b);
        @(negedge clk);
        bus.miso      = b;
        bus.sclk_rise = 1'b1;
        @(negedge clk);
        bus.sclk_rise = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) strobe_bit(b[i]);
    endtask

    task automatic send_ff(input int n);
        for (int i = 0; i < n; i++) send_byte(8'hFF);
    endtask

    task automatic start(input sd_mode_e m);
        @(negedge clk);
        bus.mode = m;
        bus.en   = 1'b1;
        @(negedge clk);
    endtask

    task automatic stop();
        @(negedge clk);
        bus.en = 1'b0;
        @(negedge clk);
    endtask

    // Reference CRC16-CCITT (init 0, MSB first) over the payload byte sequence i%256.
    function automatic logic [15:0] crc_model(input int n);
        logic [15:0] c;
        logic [7:0]  b;
        logic        fb;
        c = 16'h0000;
        for (int i = 0; i < n; i++) begin
            b = i[7:0];
            for (int k = 7; k >= 0; k--) begin
                fb = c[15] ^ b[k];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction

    task automatic run_block(input logic flip);
        logic [15:0] crc;
        int bad;
        rxq.delete();
        start(MODE_BLOCK);
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_byte(8'hFE);
        check("blk_busy_after_token", bus.busy, 1);
        check("blk_token_not_delivered", rxq.size(), 0);
        for (int i = 0; i < 512; i++) send_byte(i[7:0]);
        check("blk_count", rxq.size(), 512);
        check("blk_not_done_before_crc", bus.done, 0);
        bad = 0;
        for (int i = 0; i < rxq.size(); i++) if (rxq[i] !== i[7:0]) bad++;
        check("blk_order", bad, 0);
        crc = crc_model(512) ^ {15'b0, flip};
        send_byte(crc[15:8]);
        send_byte(crc[7:0]);
        check("blk_done", bus.done, 1);
        check("blk_crc_ok", bus.crc_ok, {31'b0, !flip});
        check("blk_token_err", bus.token_err, 0);
        check("blk_timeout", bus.timeout, 0);
        check("blk_crc_not_delivered", rxq.size(), 512);
        stop();
        check("blk_crc_ok_cleared", bus.crc_ok, 0);
        check("blk_done_cleared", bus.done, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        bus.en        = 1'b0;
        bus.sclk_rise = 1'b0;
        bus.miso      = 1'b1;
        bus.mode      = MODE_RAW;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_rx_valid", bus.rx_valid, 0);
        check("rst_rx_data", bus.rx_data, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_timeout", bus.timeout, 0);
        check("rst_token_err", bus.token_err, 0);
        check("rst_crc_ok", bus.crc_ok, 0);

        // 1. RAW: A5 then 3C, each valid one clock after its 8th strobe
        rxq.delete();
        start(MODE_RAW);
        for (int i = 7; i >= 1; i--) strobe_bit(1'(8'hA5 >> i));
        check("raw_no_valid_before_8th", bus.rx_valid, 0);
        strobe_bit(1'b1);
        check("raw_a5_valid", bus.rx_valid, 1);
        check("raw_a5_data", bus.rx_data, 8'hA5);
        @(negedge clk);
        check("raw_valid_one_cycle", bus.rx_valid, 0);
        send_byte(8'h3C);
        check("raw_3c_valid", bus.rx_valid, 1);
        check("raw_3c_data", bus.rx_data, 8'h3C);
        check("raw_busy", bus.busy, 0);
        check("raw_done", bus.done, 0);
        check("raw_count", rxq.size(), 2);
        stop();

        // 2. R1: FF FF FF 01
        rxq.delete();
        start(MODE_R1);
        check("r1_busy_hunt", bus.busy, 1);
        send_ff(3);
        send_byte(8'h01);
        check("r1_valid", bus.rx_valid, 1);
        check("r1_data", bus.rx_data, 8'h01);
        check("r1_done", bus.done, 1);
        check("r1_timeout", bus.timeout, 0);
        check("r1_crc_ok", bus.crc_ok, 0);
        check("r1_busy_done", bus.busy, 0);
        send_byte(8'h00);
        check("r1_done_ignores_strobes", rxq.size(), 1);
        stop();
        check("r1_done_cleared", bus.done, 0);

        // 3a. R1 timeout after 8 idle bytes
        rxq.delete();
        start(MODE_R1);
        send_ff(7);
        check("r1to_not_done_at_7", bus.done, 0);
        send_byte(8'hFF);
        check("r1to_done", bus.done, 1);
        check("r1to_timeout", bus.timeout, 1);
        check("r1to_no_valid", rxq.size(), 0);
        stop();
        check("r1to_timeout_cleared", bus.timeout, 0);

        // 3b. BLOCK token timeout after 2048 idle bytes
        rxq.delete();
        start(MODE_BLOCK);
        send_ff(2047);
        check("blkto_not_done_at_2047", bus.done, 0);
        send_byte(8'hFF);
        check("blkto_done", bus.done, 1);
        check("blkto_timeout", bus.timeout, 1);
        check("blkto_no_valid", rxq.size(), 0);
        stop();

        // 4. Full block with matching CRC
        run_block(1'b0);
`ifdef SD_RX_CRC16_EN
        run_block(1'b1);
`endif

        // 5. Data error token
        rxq.delete();
        start(MODE_BLOCK);
        send_byte(8'hFF);
        send_byte(8'h08);
        check("etok_valid", bus.rx_valid, 1);
        check("etok_data", bus.rx_data, 8'h08);
        check("etok_token_err", bus.token_err, 1);
        check("etok_done", bus.done, 1);
        check("etok_crc_ok", bus.crc_ok, 0);
        check("etok_count", rxq.size(), 1);
        stop();
        check("etok_cleared", bus.token_err, 0);

        // 6. Abort mid-byte (en drop coincides with a strobe), then a clean byte
        rxq.delete();
        start(MODE_R1);
        for (int i = 0; i < 5; i++) strobe_bit(1'(i & 1));
        check("abort_busy_before", bus.busy, 1);
        @(negedge clk);
        bus.en        = 1'b0;
        bus.sclk_rise = 1'b1;
        bus.miso      = 1'b0;
        @(negedge clk);
        bus.sclk_rise = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_timeout", bus.timeout, 0);
        check("abort_token_err", bus.token_err, 0);
        check("abort_no_valid", rxq.size(), 0);
        @(negedge clk);
        start(MODE_R1);
        send_byte(8'h5A);
        check("abort_next_valid", bus.rx_valid, 1);
        check("abort_next_data", bus.rx_data, 8'h5A);
        check("abort_next_done", bus.done, 1);
        check("abort_next_count", rxq.size(), 1);
        stop();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
